// File: rtl/led_out_pio_pkg.sv
// rtl/led_out_pio_pkg.sv - shared constants for the LED output PIO
//
// Purpose: register word addresses and STATUS bit position shared by the
//          LED output PIO top level and its testbench.
// Ports:   none (package).
package led_out_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - half-period counter and blink phase generator
//
// Purpose: counts 0..period-1 and toggles phase at each terminal count.
//          period == 0 parks the timer (cnt 0, phase 1); restart forces the
//          same state and wins over a simultaneous terminal count.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   period   in   DIV_W  half-period in clk cycles
//   restart  in   1      resynchronise counter (PERIOD register written)
//   phase    out  1      blink phase, 1 = blinking LEDs lit
module led_blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] period,
    input  logic             restart,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             terminal;

    // >= rather than == so a counter that somehow sits beyond the terminal
    // value still wraps instead of running the full DIV_W range.
    assign terminal = (cnt_q >= (period - 1'b1));

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (terminal) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_out_pio.sv
// rtl/led_out_pio.sv - Avalon-MM LED output port with set/clear and blink
//
// Purpose: holds a software LED pattern with atomic set/clear registers and a
//          hardware blink generator; readdata is registered (1 cycle latency).
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   3      word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe, qualified by chipselect
//   writedata   in   32     write data
//   readdata    out  32     registered read data
//   out_port    out  WIDTH  registered LED drive
module led_out_pio
    import led_out_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          DIV_W       = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_en_q, blink_en_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;

    logic             wr_en;
    logic             period_wr;
    logic             phase;
    logic [WIDTH-1:0] wdata_w;
    logic             unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign period_wr = wr_en && (address == ADDR_PERIOD);
    assign wdata_w   = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    led_blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (period_wr),
        .phase   (phase)
    );

    // Write decode
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = wdata_w;
                ADDR_BLINK_EN: blink_en_d = wdata_w;
                ADDR_PERIOD:   period_d   = writedata[DIV_W-1:0];
                ADDR_OUTSET:   data_d     = data_q | wdata_w;
                ADDR_OUTCLEAR: data_d     = data_q & ~wdata_w;
                default:       ;
            endcase
        end
    end

    // Read mux: sampled every edge regardless of chipselect, so a read of a
    // register written in the same cycle returns its pre-write value.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = data_q;
            ADDR_BLINK_EN: readdata_d[WIDTH-1:0] = blink_en_q;
            ADDR_PERIOD:   readdata_d[DIV_W-1:0] = period_q;
            ADDR_STATUS:   readdata_d[STATUS_PHASE_BIT] = phase;
            default:       ;
        endcase
    end

    // Output is built from registered state, so it trails register writes and
    // phase toggles by exactly one edge.
    always_comb begin
        out_port_d = data_q & ~(blink_en_q & {WIDTH{~phase}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            blink_en_q <= '0;
            period_q   <= '0;
            readdata_q <= '0;
            out_port_q <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
            out_port_q <= out_port_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_led_out_pio.sv
// tb/tb_led_out_pio.sv - directed self-checking bench for led_out_pio
module tb_led_out_pio;
    import led_out_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks   = 0;
    int failures = 0;

    led_out_pio #(
        .WIDTH       (8),
        .RESET_VALUE (32'h0000_00A5),
        .DIV_W       (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts and ends on a negedge; the strobe is sampled at the posedge between.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    logic [31:0] rv;
    logic        ph;

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out", {24'h0, out_port}, 32'hA5);
        check_eq("rst_rd", readdata, 32'h0);

        reset_n = 1'b1;
        do_read(ADDR_DATA, rv);
        check_eq("rd_data_rst", rv, 32'hA5);
        do_read(ADDR_STATUS, rv);
        check_eq("rd_status_rst", rv, 32'h1);

        // DATA, OUTSET, OUTCLEAR with upper writedata bits dropped
        do_write(ADDR_DATA, 32'hFFFF_FF3C, 1'b1);
        check_eq("data_out_pre", {24'h0, out_port}, 32'hA5);
        @(negedge clk);
        check_eq("data_out", {24'h0, out_port}, 32'h3C);
        do_write(ADDR_OUTSET, 32'h0000_0181, 1'b1);
        check_eq("set_out_pre", {24'h0, out_port}, 32'h3C);
        @(negedge clk);
        check_eq("set_out", {24'h0, out_port}, 32'hBD);
        do_write(ADDR_OUTCLEAR, 32'hFFFF_000C, 1'b1);
        check_eq("clr_out_pre", {24'h0, out_port}, 32'hBD);
        @(negedge clk);
        check_eq("clr_out", {24'h0, out_port}, 32'hB1);
        do_read(ADDR_DATA, rv);
        check_eq("rd_data_b1", rv, 32'hB1);

        // Blink with PERIOD = 3
        do_write(ADDR_DATA, 32'hFF, 1'b1);
        do_write(ADDR_BLINK_EN, 32'h0F, 1'b1);
        do_write(ADDR_PERIOD, 32'h3, 1'b1);
        address = ADDR_STATUS;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ph = ((((k - 1) / 3) % 2) == 0);
            check_eq($sformatf("blink3_out_k%0d", k), {24'h0, out_port}, ph ? 32'hFF : 32'hF0);
            check_eq($sformatf("blink3_st_k%0d", k), readdata, {31'h0, ph});
        end

        // PERIOD write lands on a terminal count: restart wins, no toggle
        repeat (2) @(negedge clk);
        do_write(ADDR_PERIOD, 32'h5, 1'b1);
        address = ADDR_STATUS;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            ph = ((k - 1) < 5);
            check_eq($sformatf("tc_out_k%0d", k), {24'h0, out_port}, ph ? 32'hFF : 32'hF0);
            check_eq($sformatf("tc_st_k%0d", k), readdata, {31'h0, ph});
        end

        // PERIOD = 0 while phase = 0 parks phase at 1
        do_write(ADDR_PERIOD, 32'h0, 1'b1);
        check_eq("p0_out_pre", {24'h0, out_port}, 32'hF0);
        address = ADDR_STATUS;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("p0_out_k%0d", k), {24'h0, out_port}, 32'hFF);
            check_eq($sformatf("p0_st_k%0d", k), readdata, 32'h1);
        end

        // Ignored writes and zero-reading addresses
        do_write(3'd6, 32'h0, 1'b1);
        do_write(3'd7, 32'h0, 1'b1);
        do_write(ADDR_DATA, 32'h0, 1'b0);
        do_write(ADDR_BLINK_EN, 32'h0, 1'b0);
        do_write(ADDR_PERIOD, 32'h7, 1'b0);
        do_read(ADDR_DATA, rv);
        check_eq("ign_data", rv, 32'hFF);
        do_read(ADDR_BLINK_EN, rv);
        check_eq("ign_blink", rv, 32'h0F);
        do_read(ADDR_PERIOD, rv);
        check_eq("ign_period", rv, 32'h0);
        check_eq("ign_out", {24'h0, out_port}, 32'hFF);
        for (int a = 4; a <= 7; a++) begin
            do_read(a[2:0], rv);
            check_eq($sformatf("rd_zero_a%0d", a), rv, 32'h0);
        end

        // Asynchronous reset in the middle of a blink cycle
        do_write(ADDR_PERIOD, 32'h2, 1'b1);
        address = ADDR_DATA;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_out", {24'h0, out_port}, 32'hA5);
        check_eq("async_rst_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        do_read(ADDR_DATA, rv);
        check_eq("post_rst_data", rv, 32'hA5);
        do_read(ADDR_PERIOD, rv);
        check_eq("post_rst_period", rv, 32'h0);
        do_read(ADDR_BLINK_EN, rv);
        check_eq("post_rst_blink", rv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
